memory_order_queue: RTL and testbench
=====================================

MEMORY_ORDER_QUEUE -- requirements
Module: memory_order_queue

Interface
REQ-001 SHALL have parameter LQ_DEPTH, default 8, meaning load-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter SQ_DEPTH, default 8, meaning store-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning memory address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, meaning store/load data width.
REQ-005 SHALL have parameter TAG_WIDTH, default 6, meaning active-list id width.
REQ-006 SHALL use one clock and a synchronous, active-low reset; ports: clk in 1 (rising edge), rst_n in 1 (synchronous active-low reset).
REQ-007 SHALL have ports: alloc_valid in 1 (dispatch request); alloc_is_load in 1; alloc_tag in TAG_WIDTH; alloc_ready out 1 (target queue not full).
REQ-008 SHALL have ports: agu_valid in 1; agu_is_load in 1; agu_tag in TAG_WIDTH; agu_addr in ADDR_WIDTH; agu_data in DATA_WIDTH (store data; ignored for loads).
REQ-009 SHALL have ports: commit_load in 1 (pop LQ head); commit_store in 1 (mark oldest uncommitted store committed); flush in 1 (misprediction squash).
REQ-010 SHALL have ports: ld_req_valid out 1; ld_req_ready in 1; ld_req_addr out ADDR_WIDTH; ld_req_tag out TAG_WIDTH (d-cache read).
REQ-011 SHALL have ports: ld_fwd_valid out 1; ld_fwd_tag out TAG_WIDTH; ld_fwd_data out DATA_WIDTH (store-to-load forward).
REQ-012 SHALL have ports: st_req_valid out 1; st_req_ready in 1; st_req_addr out ADDR_WIDTH; st_req_data out DATA_WIDTH (d-cache write).
REQ-013 SHALL have ports: lq_count out clog2(LQ_DEPTH)+1; sq_count out clog2(SQ_DEPTH)+1.

Function
REQ-014 Both queues SHALL be circular, pointers clog2(DEPTH)+1 bits with wrap bit; full = index equal and wrap differs; empty = pointers equal.
REQ-015 Load entry fields: tag, addr, addr_valid, issued, sq_snap (SQ tail pointer at allocation). Store entry fields: tag, addr, data, addr_valid, committed.
REQ-016 alloc_ready SHALL be 1 iff the queue selected by alloc_is_load is not full; allocation occurs on alloc_valid & alloc_ready & !flush, entry cleared, tail+1.
REQ-017 agu_valid SHALL write addr (and data for stores), set addr_valid in the occupied entry of the selected queue whose tag equals agu_tag; no match -> no effect; visible next cycle.
REQ-018 Older stores of a load = SQ entries from SQ head up to (excluding) the load's sq_snap.
REQ-019 Load selection (combinational from state): oldest LQ entry with addr_valid & !issued whose older stores all have addr_valid; others wait.
REQ-020 If the youngest older store with equal address exists: ld_fwd_valid=1 with that store's data and load tag, ld_req_valid=0; issued set at the edge.
REQ-021 Otherwise ld_req_valid=1 with load addr/tag; issued set only on ld_req_ready; ld_req outputs SHALL hold stable while valid & !ready unless flush.
REQ-022 At most one load selected per cycle.
REQ-023 commit_load SHALL pop LQ head; commit_store SHALL set committed on oldest uncommitted store (separate commit pointer).
REQ-024 st_req_valid=1 iff SQ head committed & addr_valid; pop head on st_req_ready.
REQ-025 flush SHALL: LQ tail := LQ head (empty after same-cycle commit_load applied); SQ tail := SQ commit pointer (after same-cycle commit_store applied); committed stores keep draining; allocation and AGU writes that cycle ignored; ld_req_valid/ld_fwd_valid forced 0.
REQ-026 Simultaneous alloc and pop in one queue SHALL both apply; count unchanged.
REQ-027 commit_load on empty LQ or commit_store with no uncommitted store SHALL be ignored.

Reset
REQ-028 On clk edge with rst_n=0: all pointers 0, all valid/issued/committed bits 0, counts 0, ld_req_valid=ld_fwd_valid=st_req_valid=0, alloc_ready=1; reset SHALL override all inputs mid-operation.

Verification
REQ-029 Alloc store tag 1, AGU addr 0x100 data 0xAA; alloc load tag 2, AGU addr 0x100 -> ld_fwd_valid=1, data 0xAA, tag 2, ld_req_valid=0.
REQ-030 Store tag 1 addr unknown, load tag 2 addr 0x200 valid -> ld_req_valid=0 until store AGU addr 0x300, then ld_req_valid=1 addr 0x200.
REQ-031 Fill SQ with 8 stores -> alloc_ready=0 for store, 1 for load; commit_store + st_req_ready pops one -> sq_count 7, alloc_ready=1; wrap pointer over 3 fills.
REQ-032 3 stores (1 committed), 2 loads, flush -> lq_count 0, sq_count 1, committed store drains with st_req_valid=1.
REQ-033 ld_req_ready=0 for 4 cycles -> ld_req_addr/tag stable; assert rst_n=0 mid-stall -> all outputs reset values next edge.

Source files
------------

// File: rtl/memory_order_queue.sv
// Load/store queue pair: address tracking, store-to-load forwarding,
// in-order d-cache load issue and committed-store drain.
module memory_order_queue #(
    parameter int LQ_DEPTH   = 8,
    parameter int SQ_DEPTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid,
    input  logic                          alloc_is_load,
    input  logic [TAG_WIDTH-1:0]          alloc_tag,
    output logic                          alloc_ready,
    input  logic                          agu_valid,
    input  logic                          agu_is_load,
    input  logic [TAG_WIDTH-1:0]          agu_tag,
    input  logic [ADDR_WIDTH-1:0]         agu_addr,
    input  logic [DATA_WIDTH-1:0]         agu_data,
    input  logic                          commit_load,
    input  logic                          commit_store,
    input  logic                          flush,
    output logic                          ld_req_valid,
    input  logic                          ld_req_ready,
    output logic [ADDR_WIDTH-1:0]         ld_req_addr,
    output logic [TAG_WIDTH-1:0]          ld_req_tag,
    output logic                          ld_fwd_valid,
    output logic [TAG_WIDTH-1:0]          ld_fwd_tag,
    output logic [DATA_WIDTH-1:0]         ld_fwd_data,
    output logic                          st_req_valid,
    input  logic                          st_req_ready,
    output logic [ADDR_WIDTH-1:0]         st_req_addr,
    output logic [DATA_WIDTH-1:0]         st_req_data,
    output logic [$clog2(LQ_DEPTH):0]     lq_count,
    output logic [$clog2(SQ_DEPTH):0]     sq_count
);
    localparam int LQ_IW = $clog2(LQ_DEPTH);
    localparam int LQ_PW = LQ_IW + 1;
    localparam int SQ_IW = $clog2(SQ_DEPTH);
    localparam int SQ_PW = SQ_IW + 1;

    logic [TAG_WIDTH-1:0]  lq_tag  [LQ_DEPTH];
    logic [ADDR_WIDTH-1:0] lq_addr [LQ_DEPTH];
    logic [SQ_PW-1:0]      lq_snap [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]   lq_av, lq_iss, lq_occ, lq_blk;
    logic [TAG_WIDTH-1:0]  sq_tag  [SQ_DEPTH];
    logic [ADDR_WIDTH-1:0] sq_addr [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] sq_data [SQ_DEPTH];
    logic [SQ_DEPTH-1:0]   sq_av, sq_com, sq_occ;

    logic [LQ_PW-1:0] lq_head, lq_tail, lq_head_n, lq_tail_n;
    logic [SQ_PW-1:0] sq_head, sq_tail, sq_cmt;
    logic [SQ_PW-1:0] sq_head_n, sq_tail_n, sq_cmt_n;
    logic             lq_full, lq_empty, sq_full, sq_empty;
    logic             alloc_ld, alloc_st, lq_pop, st_pop, cmt_st;
    logic             sel_found, fwd_hit, do_issue, lk_valid;
    logic [LQ_IW-1:0] sel_idx, lk_idx;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [SQ_IW-1:0] sq_hi;

    // Number of stores between SQ head and a load's snapshot.
    function automatic logic [SQ_PW-1:0] n_older(
        input logic [SQ_PW-1:0] snap,
        input logic [SQ_PW-1:0] head,
        input logic [SQ_PW-1:0] cnt
    );
        logic [SQ_PW-1:0] d;
        d = snap - head;
        return (d > cnt) ? cnt : d;
    endfunction

    assign lq_full  = (lq_head[LQ_IW-1:0] == lq_tail[LQ_IW-1:0])
                   && (lq_head[LQ_IW] != lq_tail[LQ_IW]);
    assign lq_empty = (lq_head == lq_tail);
    assign sq_full  = (sq_head[SQ_IW-1:0] == sq_tail[SQ_IW-1:0])
                   && (sq_head[SQ_IW] != sq_tail[SQ_IW]);
    assign sq_empty = (sq_head == sq_tail);
    assign lq_count = lq_tail - lq_head;
    assign sq_count = sq_tail - sq_head;

    assign alloc_ready = alloc_is_load ? !lq_full : !sq_full;
    assign alloc_ld = alloc_valid && alloc_is_load && !lq_full && !flush;
    assign alloc_st = alloc_valid && !alloc_is_load && !sq_full && !flush;
    assign lq_pop   = commit_load && !lq_empty;
    assign cmt_st   = commit_store && (sq_cmt != sq_tail);

    assign sq_hi        = sq_head[SQ_IW-1:0];
    assign st_req_valid = !sq_empty && sq_com[sq_hi] && sq_av[sq_hi];
    assign st_req_addr  = sq_addr[sq_hi];
    assign st_req_data  = sq_data[sq_hi];
    assign st_pop       = st_req_valid && st_req_ready;

    assign lq_head_n = lq_head + LQ_PW'(lq_pop);
    assign lq_tail_n = flush ? lq_head_n : lq_tail + LQ_PW'(alloc_ld);
    assign sq_head_n = sq_head + SQ_PW'(st_pop);
    assign sq_cmt_n  = sq_cmt + SQ_PW'(cmt_st);
    assign sq_tail_n = flush ? sq_cmt_n : sq_tail + SQ_PW'(alloc_st);

    always_comb begin
        lq_occ = '0;
        sq_occ = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            lq_occ[i] = LQ_PW'(LQ_IW'(i) - lq_head[LQ_IW-1:0]) < lq_count;
        for (int i = 0; i < SQ_DEPTH; i++)
            sq_occ[i] = SQ_PW'(SQ_IW'(i) - sq_head[SQ_IW-1:0]) < sq_count;
    end

    // A load is blocked while any older store still lacks its address.
    always_comb begin
        lq_blk = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            for (int j = 0; j < SQ_DEPTH; j++) begin
                if (SQ_PW'(j) < n_older(lq_snap[i], sq_head, sq_count)
                    && !sq_av[SQ_IW'(sq_hi + SQ_IW'(j))])
                    lq_blk[i] = 1'b1;
            end
        end
    end

    // A stalled d-cache request keeps its slot until accepted.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (lk_valid && lq_occ[lk_idx] && !lq_iss[lk_idx]) begin
            sel_found = 1'b1;
            sel_idx   = lk_idx;
        end else begin
            for (int k = 0; k < LQ_DEPTH; k++) begin
                if (!sel_found
                    && lq_occ[LQ_IW'(lq_head[LQ_IW-1:0] + LQ_IW'(k))]
                    && lq_av[LQ_IW'(lq_head[LQ_IW-1:0] + LQ_IW'(k))]
                    && !lq_iss[LQ_IW'(lq_head[LQ_IW-1:0] + LQ_IW'(k))]
                    && !lq_blk[LQ_IW'(lq_head[LQ_IW-1:0] + LQ_IW'(k))]) begin
                    sel_found = 1'b1;
                    sel_idx   = LQ_IW'(lq_head[LQ_IW-1:0] + LQ_IW'(k));
                end
            end
        end
    end

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (sel_found && !(lk_valid && sel_idx == lk_idx)) begin
            for (int j = 0; j < SQ_DEPTH; j++) begin
                if (SQ_PW'(j) < n_older(lq_snap[sel_idx], sq_head, sq_count)
                    && sq_addr[SQ_IW'(sq_hi + SQ_IW'(j))] == lq_addr[sel_idx]) begin
                    fwd_hit  = 1'b1;
                    fwd_data = sq_data[SQ_IW'(sq_hi + SQ_IW'(j))];
                end
            end
        end
    end

    assign ld_fwd_valid = sel_found && fwd_hit && !flush;
    assign ld_fwd_tag   = lq_tag[sel_idx];
    assign ld_fwd_data  = fwd_data;
    assign ld_req_valid = sel_found && !fwd_hit && !flush;
    assign ld_req_addr  = lq_addr[sel_idx];
    assign ld_req_tag   = lq_tag[sel_idx];
    assign do_issue     = ld_fwd_valid || (ld_req_valid && ld_req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lq_head  <= '0;
            lq_tail  <= '0;
            sq_head  <= '0;
            sq_tail  <= '0;
            sq_cmt   <= '0;
            lq_av    <= '0;
            lq_iss   <= '0;
            sq_av    <= '0;
            sq_com   <= '0;
            lk_valid <= 1'b0;
            lk_idx   <= '0;
        end else begin
            lq_head  <= lq_head_n;
            lq_tail  <= lq_tail_n;
            sq_head  <= sq_head_n;
            sq_tail  <= sq_tail_n;
            sq_cmt   <= sq_cmt_n;
            lk_valid <= ld_req_valid && !ld_req_ready;
            lk_idx   <= sel_idx;
            if (do_issue)
                lq_iss[sel_idx] <= 1'b1;
            if (cmt_st)
                sq_com[sq_cmt[SQ_IW-1:0]] <= 1'b1;
            if (alloc_ld) begin
                lq_tag[lq_tail[LQ_IW-1:0]]  <= alloc_tag;
                lq_av[lq_tail[LQ_IW-1:0]]   <= 1'b0;
                lq_iss[lq_tail[LQ_IW-1:0]]  <= 1'b0;
                lq_snap[lq_tail[LQ_IW-1:0]] <= sq_tail;
            end
            if (alloc_st) begin
                sq_tag[sq_tail[SQ_IW-1:0]] <= alloc_tag;
                sq_av[sq_tail[SQ_IW-1:0]]  <= 1'b0;
                sq_com[sq_tail[SQ_IW-1:0]] <= 1'b0;
            end
            if (agu_valid && !flush) begin
                for (int i = 0; i < LQ_DEPTH; i++) begin
                    if (agu_is_load && lq_occ[i] && lq_tag[i] == agu_tag) begin
                        lq_addr[i] <= agu_addr;
                        lq_av[i]   <= 1'b1;
                    end
                end
                for (int i = 0; i < SQ_DEPTH; i++) begin
                    if (!agu_is_load && sq_occ[i] && sq_tag[i] == agu_tag) begin
                        sq_addr[i] <= agu_addr;
                        sq_data[i] <= agu_data;
                        sq_av[i]   <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_order_queue.sv
// Directed bench for memory_order_queue: forwarding, blocking,
// full/wrap, flush and stall/reset behaviour.
module tb_memory_order_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, alloc_is_load, alloc_ready;
    logic [5:0]  alloc_tag;
    logic        agu_valid, agu_is_load;
    logic [5:0]  agu_tag;
    logic [31:0] agu_addr, agu_data;
    logic        commit_load, commit_store, flush;
    logic        ld_req_valid, ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [5:0]  ld_req_tag;
    logic        ld_fwd_valid;
    logic [5:0]  ld_fwd_tag;
    logic [31:0] ld_fwd_data;
    logic        st_req_valid, st_req_ready;
    logic [31:0] st_req_addr, st_req_data;
    logic [3:0]  lq_count, sq_count;

    int checks = 0;
    int failures = 0;

    memory_order_queue dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_is_load(alloc_is_load),
        .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
        .agu_valid(agu_valid), .agu_is_load(agu_is_load),
        .agu_tag(agu_tag), .agu_addr(agu_addr), .agu_data(agu_data),
        .commit_load(commit_load), .commit_store(commit_store),
        .flush(flush),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_tag(ld_fwd_tag),
        .ld_fwd_data(ld_fwd_data),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_addr(st_req_addr), .st_req_data(st_req_data),
        .lq_count(lq_count), .sq_count(sq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic do_alloc(input logic ld, input logic [5:0] tag);
        alloc_valid = 1'b1;
        alloc_is_load = ld;
        alloc_tag = tag;
        tick();
        alloc_valid = 1'b0;
        #1;
    endtask

    task automatic do_agu(input logic ld, input logic [5:0] tag,
                          input logic [31:0] addr, input logic [31:0] data);
        agu_valid = 1'b1;
        agu_is_load = ld;
        agu_tag = tag;
        agu_addr = addr;
        agu_data = data;
        tick();
        agu_valid = 1'b0;
        #1;
    endtask

    task automatic chk_reset(input string tag);
        alloc_is_load = 1'b0;
        #1;
        chk({tag, "_ldreq"}, ld_req_valid, 0);
        chk({tag, "_ldfwd"}, ld_fwd_valid, 0);
        chk({tag, "_streq"}, st_req_valid, 0);
        chk({tag, "_lqcnt"}, lq_count, 0);
        chk({tag, "_sqcnt"}, sq_count, 0);
        chk({tag, "_rdy"}, alloc_ready, 1);
    endtask

    // Fill the empty SQ with 8 stores, then commit and drain them in order.
    task automatic fill_drain(input logic [31:0] base);
        int n;
        for (int k = 0; k < 8; k++) do_alloc(1'b0, 6'(k));
        alloc_is_load = 1'b0;
        #1;
        chk("fd_full_cnt", sq_count, 8);
        chk("fd_full_rdy", alloc_ready, 0);
        for (int k = 0; k < 8; k++)
            do_agu(1'b0, 6'(k), base + 32'(k * 4), 32'(k));
        n = 0;
        st_req_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            commit_store = (t < 8);
            #1;
            if (st_req_valid && n < 8) begin
                chk("fd_addr", st_req_addr, base + 32'(n * 4));
                n++;
            end
            tick();
        end
        commit_store = 1'b0;
        st_req_ready = 1'b0;
        #1;
        chk("fd_drained", n, 8);
        chk("fd_empty", sq_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        alloc_valid = 0; alloc_is_load = 0; alloc_tag = 0;
        agu_valid = 0; agu_is_load = 0; agu_tag = 0;
        agu_addr = 0; agu_data = 0;
        commit_load = 0; commit_store = 0; flush = 0;
        ld_req_ready = 0; st_req_ready = 0;
        tick();
        do_reset();
        chk_reset("rst");

        // Empty commits are ignored.
        commit_load = 1'b1;
        commit_store = 1'b1;
        tick();
        commit_load = 1'b0;
        commit_store = 1'b0;
        #1;
        chk("emptycl_lq", lq_count, 0);
        chk("emptycs_sq", sq_count, 0);
        do_alloc(1'b0, 6'd3);
        do_agu(1'b0, 6'd3, 32'h80, 32'h1);
        chk("nocommit_st", st_req_valid, 0);

        // Store-to-load forwarding.
        do_reset();
        do_alloc(1'b0, 6'd1);
        do_agu(1'b0, 6'd1, 32'h100, 32'hAA);
        do_alloc(1'b1, 6'd2);
        do_agu(1'b1, 6'd2, 32'h100, 32'h0);
        chk("fwd_valid", ld_fwd_valid, 1);
        chk("fwd_data", ld_fwd_data, 32'hAA);
        chk("fwd_tag", ld_fwd_tag, 2);
        chk("fwd_noreq", ld_req_valid, 0);
        tick();
        chk("fwd_issued", ld_fwd_valid, 0);

        // Load waits on unknown older store address, then stalls.
        do_reset();
        do_alloc(1'b0, 6'd1);
        do_alloc(1'b1, 6'd2);
        do_agu(1'b1, 6'd2, 32'h200, 32'h0);
        chk("blk_noreq", ld_req_valid, 0);
        chk("blk_nofwd", ld_fwd_valid, 0);
        do_agu(1'b0, 6'd1, 32'h300, 32'h5);
        chk("unblk_req", ld_req_valid, 1);
        chk("unblk_addr", ld_req_addr, 32'h200);
        chk("unblk_tag", ld_req_tag, 2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("stall_valid", ld_req_valid, 1);
            chk("stall_addr", ld_req_addr, 32'h200);
            chk("stall_tag", ld_req_tag, 2);
        end
        ld_req_ready = 1'b1;
        tick();
        ld_req_ready = 1'b0;
        #1;
        chk("accepted", ld_req_valid, 0);
        do_alloc(1'b1, 6'd3);
        do_agu(1'b1, 6'd3, 32'h204, 32'h0);
        chk("stall2_req", ld_req_valid, 1);
        chk("stall2_addr", ld_req_addr, 32'h204);
        tick();
        tick();
        do_reset();
        chk_reset("midrst");

        // Full SQ, single pop.
        for (int k = 0; k < 8; k++) do_alloc(1'b0, 6'(k));
        alloc_is_load = 1'b0;
        #1;
        chk("full_cnt", sq_count, 8);
        chk("full_st_rdy", alloc_ready, 0);
        alloc_is_load = 1'b1;
        #1;
        chk("full_ld_rdy", alloc_ready, 1);
        do_agu(1'b0, 6'd0, 32'h40, 32'h55);
        commit_store = 1'b1;
        tick();
        commit_store = 1'b0;
        #1;
        chk("head_valid", st_req_valid, 1);
        chk("head_addr", st_req_addr, 32'h40);
        chk("head_data", st_req_data, 32'h55);
        st_req_ready = 1'b1;
        tick();
        st_req_ready = 1'b0;
        alloc_is_load = 1'b0;
        #1;
        chk("pop_cnt", sq_count, 7);
        chk("pop_rdy", alloc_ready, 1);

        // Three fills wrap the SQ pointers.
        do_reset();
        fill_drain(32'h1000);
        fill_drain(32'h2000);
        fill_drain(32'h3000);

        // Flush keeps only the committed store.
        do_reset();
        do_alloc(1'b0, 6'd1);
        do_alloc(1'b0, 6'd2);
        do_alloc(1'b0, 6'd3);
        agu_valid = 1'b1; agu_is_load = 1'b0; agu_tag = 6'd1;
        agu_addr = 32'h10; agu_data = 32'h11;
        commit_store = 1'b1;
        tick();
        agu_valid = 1'b0;
        commit_store = 1'b0;
        do_alloc(1'b1, 6'd4);
        do_alloc(1'b1, 6'd5);
        chk("pre_lq", lq_count, 2);
        chk("pre_sq", sq_count, 3);
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_is_load = 1'b1; alloc_tag = 6'd9;
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        #1;
        chk("fl_lq", lq_count, 0);
        chk("fl_sq", sq_count, 1);
        chk("fl_st_valid", st_req_valid, 1);
        chk("fl_st_addr", st_req_addr, 32'h10);
        chk("fl_st_data", st_req_data, 32'h11);
        st_req_ready = 1'b1;
        tick();
        st_req_ready = 1'b0;
        #1;
        chk("fl_drained", sq_count, 0);
        do_alloc(1'b0, 6'd7);
        chk("fl_realloc", sq_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
